// File: rtl/hs32_memarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hs32_mem_pkg
//  Purpose  : Shared types for the HS32 two-channel memory arbiter:
//             FSM state encoding and timeout counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package hs32_mem_pkg;

  // Width of the BUSY-phase wait counter
  localparam int c_TO_CNT_W = 8;

  typedef logic [c_TO_CNT_W-1:0] to_cnt_t;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : hs32_mem_pkg
`default_nettype wire

// File: rtl/hs32_memarb_if.sv
`default_nettype none
// ============================================================================
//  Module   : hs32_memarb_if
//  Purpose  : Bundles the external memory bus and both requester channels
//             of the HS32 arbiter. The master modport is the arbiter view,
//             the slave modport is the memory/requester environment view.
//  Revision : 1.0 - initial release
// ============================================================================
interface hs32_memarb_if;

  // External memory bus
  logic [31:0] addr;
  logic        rw;
  logic [31:0] dout;
  logic [31:0] din;
  logic        valid;
  logic        ready;

  // Requester channel 0
  logic [31:0] addr0;
  logic        rw0;
  logic [31:0] dtw0;
  logic        req0;
  logic [31:0] dtr0;
  logic        rdy0;

  // Requester channel 1
  logic [31:0] addr1;
  logic        rw1;
  logic [31:0] dtw1;
  logic        req1;
  logic [31:0] dtr1;
  logic        rdy1;

  // Timed-out completion flag, qualifies rdy0/rdy1
  logic        err;

  modport master (
    output addr, rw, dout, valid,
    input  din, ready,
    input  addr0, rw0, dtw0, req0,
    output dtr0, rdy0,
    input  addr1, rw1, dtw1, req1,
    output dtr1, rdy1,
    output err
  );

  modport slave (
    input  addr, rw, dout, valid,
    output din, ready,
    output addr0, rw0, dtw0, req0,
    input  dtr0, rdy0,
    output addr1, rw1, dtw1, req1,
    input  dtr1, rdy1,
    input  err
  );

endinterface : hs32_memarb_if
`default_nettype wire

// File: rtl/hs32_memarb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : hs32_rr_pick
//  Purpose  : Combinational two-way tie-break. A lone request always wins;
//             on a tie the channel that was not served last is picked.
//  Revision : 1.0 - initial release
// ============================================================================
module hs32_rr_pick (
  input  wire req0,
  input  wire req1,
  input  wire lst,     // last served channel
  output wire gnt,     // some channel is granted
  output wire gnt_ch   // granted channel index
);

  assign gnt    = req0 | req1;
  assign gnt_ch = (req0 & req1) ? ~lst : req1;

endmodule : hs32_rr_pick
`default_nettype wire

// File: rtl/hs32_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : hs32_memarb
//  Purpose  : Two-channel memory arbiter. A granted request is latched,
//             issued on the external bus until ready (or timeout), then
//             completed with a one-cycle rdy pulse on the granted channel.
//             Every bus/channel output comes straight from a register.
//  Revision : 1.0 - initial release
// ============================================================================
module hs32_memarb
  import hs32_mem_pkg::*;
#(
  parameter int TIMEOUT = 255  // max BUSY cycles without ready; 0 = never
) (
  input  wire             clk,
  input  wire             reset,  // asynchronous, active low
  hs32_memarb_if.master   bus
);

  // Counter value at which a still-unanswered access is abandoned. TIMEOUT
  // is assumed to fit the counter (1..256).
  localparam to_cnt_t c_TO_LAST = to_cnt_t'(TIMEOUT - 1);
  localparam bit      c_TO_EN   = (TIMEOUT != 0);

  state_t      r_state, w_state_nxt;
  logic        r_ch,    w_ch_nxt;     // channel owning the current access
  logic        r_lst,   w_lst_nxt;    // last served channel
  to_cnt_t     r_cnt,   w_cnt_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_rw,    w_rw_nxt;
  logic [31:0] r_addr,  w_addr_nxt;
  logic [31:0] r_dout,  w_dout_nxt;
  logic [31:0] r_dtr0,  w_dtr0_nxt;
  logic [31:0] r_dtr1,  w_dtr1_nxt;
  logic        r_rdy0,  w_rdy0_nxt;
  logic        r_rdy1,  w_rdy1_nxt;
  logic        r_err,   w_err_nxt;

  logic        w_gnt;
  logic        w_gnt_ch;
  logic        w_timeout;
  logic [31:0] w_rdata;

  hs32_rr_pick u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .lst    (r_lst),
    .gnt    (w_gnt),
    .gnt_ch (w_gnt_ch)
  );

  // Ready has priority over timeout; a timed-out access returns zero data.
  assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);
  assign w_rdata   = bus.ready ? bus.din : 32'd0;

  // Next-state and next-output decode for the IDLE/BUSY/RESP sequence
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_lst_nxt   = r_lst;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_dtr0_nxt  = r_dtr0;
    w_dtr1_nxt  = r_dtr1;
    w_rdy0_nxt  = 1'b0;
    w_rdy1_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_gnt) begin
          w_state_nxt = BUSY;
          w_ch_nxt    = w_gnt_ch;
          w_lst_nxt   = w_gnt_ch;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = w_gnt_ch ? bus.addr1 : bus.addr0;
          w_rw_nxt    = w_gnt_ch ? bus.rw1   : bus.rw0;
          w_dout_nxt  = w_gnt_ch ? bus.dtw1  : bus.dtw0;
        end
      end

      BUSY: begin
        if (bus.ready || w_timeout) begin
          w_state_nxt = RESP;
          w_valid_nxt = 1'b0;
          w_err_nxt   = ~bus.ready;
          if (r_ch) begin
            w_dtr1_nxt = w_rdata;
            w_rdy1_nxt = 1'b1;
          end else begin
            w_dtr0_nxt = w_rdata;
            w_rdy0_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      RESP: begin
        // Return the bus lines to their idle values
        w_state_nxt = IDLE;
        w_rw_nxt    = 1'b0;
        w_addr_nxt  = 32'd0;
        w_dout_nxt  = 32'd0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ch    <= 1'b0;
      r_lst   <= 1'b1;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= 32'd0;
      r_dout  <= 32'd0;
      r_dtr0  <= 32'd0;
      r_dtr1  <= 32'd0;
      r_rdy0  <= 1'b0;
      r_rdy1  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_lst   <= w_lst_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_dtr0  <= w_dtr0_nxt;
      r_dtr1  <= w_dtr1_nxt;
      r_rdy0  <= w_rdy0_nxt;
      r_rdy1  <= w_rdy1_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.valid = r_valid;
  assign bus.rw    = r_rw;
  assign bus.addr  = r_addr;
  assign bus.dout  = r_dout;
  assign bus.dtr0  = r_dtr0;
  assign bus.dtr1  = r_dtr1;
  assign bus.rdy0  = r_rdy0;
  assign bus.rdy1  = r_rdy1;
  assign bus.err   = r_err;

endmodule : hs32_memarb
`default_nettype wire

// File: tb/tb_hs32_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs32_memarb
//  Purpose  : Directed self-checking bench for hs32_memarb. One instance
//             uses the default timeout, a second uses TIMEOUT=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs32_memarb;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  hs32_memarb_if bus();
  hs32_memarb_if bt();

  hs32_memarb #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hs32_memarb #(.TIMEOUT(4)) dut_to (
    .clk   (clk),
    .reset (reset),
    .bus   (bt)
  );

  // Packed views of all outputs, all-zero at reset
  logic [132:0] w_bus_outs;
  logic [132:0] w_bt_outs;
  assign w_bus_outs = {bus.valid, bus.rdy0, bus.rdy1, bus.err, bus.rw,
                       bus.addr, bus.dout, bus.dtr0, bus.dtr1};
  assign w_bt_outs  = {bt.valid, bt.rdy0, bt.rdy1, bt.err, bt.rw,
                       bt.addr, bt.dout, bt.dtr0, bt.dtr1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Protocol monitor: exclusive rdy, err qualified by one rdy, stable bus while valid
  logic        m_pv;
  logic [64:0] m_pbus;
  initial m_pv = 1'b0;
  always @(negedge clk) begin
    n_asserts++;
    if (bus.rdy0 && bus.rdy1) begin
      n_fail++;
      $display("FAIL mon_rdy_excl: got rdy0=%b rdy1=%b required not both", bus.rdy0, bus.rdy1);
    end
    n_asserts++;
    if (bt.err && !(bt.rdy0 ^ bt.rdy1)) begin
      n_fail++;
      $display("FAIL mon_err_rdy: got err=1 rdy0=%b rdy1=%b required exactly one rdy", bt.rdy0, bt.rdy1);
    end
    if (m_pv && bus.valid) begin
      n_asserts++;
      if ({bus.rw, bus.addr, bus.dout} !== m_pbus) begin
        n_fail++;
        $display("FAIL mon_bus_stable: got %h required %h", {bus.rw, bus.addr, bus.dout}, m_pbus);
      end
    end
    m_pv   = bus.valid;
    m_pbus = {bus.rw, bus.addr, bus.dout};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs;
    bus.din = '0; bus.ready = 1'b0;
    bus.addr0 = '0; bus.rw0 = 1'b0; bus.dtw0 = '0; bus.req0 = 1'b0;
    bus.addr1 = '0; bus.rw1 = 1'b0; bus.dtw1 = '0; bus.req1 = 1'b0;
    bt.din = '0; bt.ready = 1'b0;
    bt.addr0 = '0; bt.rw0 = 1'b0; bt.dtw0 = '0; bt.req0 = 1'b0;
    bt.addr1 = '0; bt.rw1 = 1'b0; bt.dtw1 = '0; bt.req1 = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_asserts++;
    if (w_bus_outs !== 133'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h required 0", w_bus_outs);
    end
    n_asserts++;
    if (w_bt_outs !== 133'd0) begin
      n_fail++;
      $display("FAIL reset_outs_to: got %h required 0", w_bt_outs);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read;
    bus.addr0 = 32'h100; bus.rw0 = 1'b0; bus.req0 = 1'b1; bus.ready = 1'b0;
    tick();
    n_asserts++;
    if ({bus.valid, bus.rw, bus.addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL read_issue: got valid=%b rw=%b addr=%h required 1 0 00000100", bus.valid, bus.rw, bus.addr);
    end
    bus.req0 = 1'b0;
    tick();
    n_asserts++;
    if ({bus.valid, bus.addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL read_wait: got valid=%b addr=%h required 1 00000100", bus.valid, bus.addr);
    end
    bus.ready = 1'b1; bus.din = 32'hDEADBEEF;
    tick();
    n_asserts++;
    if ({bus.rdy0, bus.rdy1, bus.err, bus.valid, bus.dtr0} !== {4'b1000, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_resp: got rdy0=%b rdy1=%b err=%b valid=%b dtr0=%h required 1 0 0 0 deadbeef",
               bus.rdy0, bus.rdy1, bus.err, bus.valid, bus.dtr0);
    end
    bus.ready = 1'b0; bus.din = 32'h0;
    tick();
    n_asserts++;
    if ({bus.rdy0, bus.valid, bus.dtr0} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_after: got rdy0=%b valid=%b dtr0=%h required 0 0 deadbeef", bus.rdy0, bus.valid, bus.dtr0);
    end
  endtask

  task automatic test_tie_alternate;
    logic [31:0] exp_addr;
    logic [31:0] got_dtr;
    do_reset();
    bus.addr0 = 32'h10; bus.addr1 = 32'h14;
    bus.ready = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.din  = 32'h1000 + 32'(i);
      tick();
      exp_addr = (i % 2 == 1) ? 32'h14 : 32'h10;
      n_asserts++;
      if ({bus.valid, bus.addr} !== {1'b1, exp_addr}) begin
        n_fail++;
        $display("FAIL tie_grant%0d: got valid=%b addr=%h required 1 %h", i, bus.valid, bus.addr, exp_addr);
      end
      tick();
      n_asserts++;
      if ({bus.rdy0, bus.rdy1} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL tie_rdy%0d: got rdy0=%b rdy1=%b required ch%0d only", i, bus.rdy0, bus.rdy1, i % 2);
      end
      got_dtr = (i % 2 == 1) ? bus.dtr1 : bus.dtr0;
      n_asserts++;
      if (got_dtr !== 32'h1000 + 32'(i)) begin
        n_fail++;
        $display("FAIL tie_dtr%0d: got %h required %h", i, got_dtr, 32'h1000 + 32'(i));
      end
      tick();
      if (i == 3) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.ready = 1'b0;
      end
      n_asserts++;
      if ({bus.rdy0, bus.rdy1, bus.valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL tie_idle%0d: got rdy0=%b rdy1=%b valid=%b required 000", i, bus.rdy0, bus.rdy1, bus.valid);
      end
    end
  endtask

  task automatic test_write_hold;
    bus.addr1 = 32'h20; bus.rw1 = 1'b1; bus.dtw1 = 32'h55; bus.req1 = 1'b1;
    tick();
    n_asserts++;
    if ({bus.valid, bus.rw, bus.addr, bus.dout} !== {2'b11, 32'h20, 32'h55}) begin
      n_fail++;
      $display("FAIL write_issue: got valid=%b rw=%b addr=%h dout=%h required 1 1 20 55",
               bus.valid, bus.rw, bus.addr, bus.dout);
    end
    bus.dtw1 = 32'h66; bus.addr1 = 32'h99; bus.req1 = 1'b0;
    tick();
    n_asserts++;
    if ({bus.valid, bus.addr, bus.dout} !== {1'b1, 32'h20, 32'h55}) begin
      n_fail++;
      $display("FAIL write_hold: got valid=%b addr=%h dout=%h required 1 20 55", bus.valid, bus.addr, bus.dout);
    end
    bus.ready = 1'b1; bus.din = 32'h77;
    tick();
    n_asserts++;
    if ({bus.rdy1, bus.rdy0, bus.valid, bus.dtr1} !== {3'b100, 32'h77}) begin
      n_fail++;
      $display("FAIL write_resp: got rdy1=%b rdy0=%b valid=%b dtr1=%h required 1 0 0 77",
               bus.rdy1, bus.rdy0, bus.valid, bus.dtr1);
    end
    bus.ready = 1'b0;
    tick();
    n_asserts++;
    if ({bus.rdy1, bus.dtr1, bus.dtr0} !== {1'b0, 32'h77, 32'h1002}) begin
      n_fail++;
      $display("FAIL write_after: got rdy1=%b dtr1=%h dtr0=%h required 0 77 1002", bus.rdy1, bus.dtr1, bus.dtr0);
    end
  endtask

  task automatic test_timeout;
    // Normal read first so a zeroed dtr0 is meaningful afterwards
    bt.addr0 = 32'h40; bt.req0 = 1'b1;
    tick();
    bt.req0 = 1'b0; bt.ready = 1'b1; bt.din = 32'hCAFE;
    tick();
    n_asserts++;
    if ({bt.rdy0, bt.err, bt.dtr0} !== {2'b10, 32'hCAFE}) begin
      n_fail++;
      $display("FAIL to_preload: got rdy0=%b err=%b dtr0=%h required 1 0 0000cafe", bt.rdy0, bt.err, bt.dtr0);
    end
    bt.ready = 1'b0;
    tick();
    bt.req0 = 1'b1;
    tick();
    bt.req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_asserts++;
      if ({bt.valid, bt.rdy0} !== 2'b10) begin
        n_fail++;
        $display("FAIL to_wait%0d: got valid=%b rdy0=%b required 1 0", k, bt.valid, bt.rdy0);
      end
      tick();
    end
    n_asserts++;
    if ({bt.rdy0, bt.err, bt.valid, bt.dtr0} !== {3'b110, 32'h0}) begin
      n_fail++;
      $display("FAIL to_expire: got rdy0=%b err=%b valid=%b dtr0=%h required 1 1 0 0",
               bt.rdy0, bt.err, bt.valid, bt.dtr0);
    end
    tick();
    n_asserts++;
    if ({bt.rdy0, bt.err} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_after: got rdy0=%b err=%b required 0 0", bt.rdy0, bt.err);
    end
  endtask

  task automatic test_timeout_ready_race;
    bt.req0 = 1'b1; bt.din = 32'hBEEF;
    tick();
    bt.req0 = 1'b0;
    repeat (3) tick();
    n_asserts++;
    if (bt.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL race_wait: got valid=%b required 1", bt.valid);
    end
    bt.ready = 1'b1;
    tick();
    n_asserts++;
    if ({bt.rdy0, bt.err, bt.dtr0} !== {2'b10, 32'hBEEF}) begin
      n_fail++;
      $display("FAIL race_resp: got rdy0=%b err=%b dtr0=%h required 1 0 0000beef", bt.rdy0, bt.err, bt.dtr0);
    end
    bt.ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy;
    bus.addr0 = 32'h300; bus.addr1 = 32'h304; bus.rw0 = 1'b0; bus.rw1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.ready = 1'b0;
    tick();
    n_asserts++;
    if ({bus.valid, bus.addr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL abort_issue: got valid=%b addr=%h required 1 00000300", bus.valid, bus.addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_asserts++;
    if (w_bus_outs !== 133'd0) begin
      n_fail++;
      $display("FAIL abort_async: got %h required 0", w_bus_outs);
    end
    tick();
    n_asserts++;
    if (w_bus_outs !== 133'd0) begin
      n_fail++;
      $display("FAIL abort_held: got %h required 0", w_bus_outs);
    end
    reset = 1'b1;
    tick();
    n_asserts++;
    if ({bus.valid, bus.addr, bus.rw} !== {1'b1, 32'h300, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_regrant: got valid=%b addr=%h rw=%b required 1 00000300 0", bus.valid, bus.addr, bus.rw);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.ready = 1'b1; bus.din = 32'h5A5A;
    tick();
    n_asserts++;
    if ({bus.rdy0, bus.rdy1, bus.dtr0} !== {2'b10, 32'h5A5A}) begin
      n_fail++;
      $display("FAIL abort_complete: got rdy0=%b rdy1=%b dtr0=%h required 1 0 00005a5a", bus.rdy0, bus.rdy1, bus.dtr0);
    end
    bus.ready = 1'b0;
    tick();
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    init_inputs();
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_write_hold();
    test_timeout();
    test_timeout_ready_race();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_hs32_memarb
`default_nettype wire

// File: doc/hs32_memarb.md
HS32_MEMARB -- requirements
Module: hs32_memarb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving max cycles waiting for ready; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have external bus ports: addr out 32; rw out 1 (1=write); dout out 32; din in 32; valid out 1; ready in 1 (op complete, din valid).
REQ-005 SHALL have, per channel n in {0,1}: addrn in 32; rwn in 1; dtwn in 32; reqn in 1; dtrn out 32; rdyn out 1 (one-cycle completion pulse).
REQ-006 SHALL have err output, 1 bit, asserted only together with rdy0/rdy1 to flag a timed-out transaction.

Function
REQ-007 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; reset state IDLE.
REQ-008 IDLE: if no reqn is high, stay IDLE and keep all outputs at reset values.
REQ-009 IDLE, exactly one reqn high: grant channel n, latch addrn/rwn/dtwn into output registers, go to BUSY.
REQ-010 IDLE, both req high: grant the channel not recorded in last-served register lst; lst reset value 1, so channel 0 wins the first tie.
REQ-011 lst SHALL update to the granted channel on every grant.
REQ-012 BUSY: valid=1; addr/rw/dout driven from latched registers only, unaffected by channel input changes or req deassertion.
REQ-013 valid SHALL rise the cycle after the request is sampled in IDLE (1-cycle issue latency).
REQ-014 BUSY with ready=1: capture din, go to RESP; valid=0 in RESP.
REQ-015 RESP: rdy of granted channel =1 for exactly one cycle; other rdy =0; dtr of granted channel = captured din; then IDLE.
REQ-016 dtr0/dtr1 SHALL hold their last captured value until the next completion on that channel.
REQ-017 rw=1 completion SHALL still capture din; requester ignores it.
REQ-018 Timeout: 8-bit counter cleared on entering BUSY, increments each BUSY cycle without ready.
REQ-019 When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ready, go to RESP with err=1 and captured data 0.
REQ-020 ready and timeout in the same cycle: ready wins, err=0.
REQ-021 ready SHALL be ignored in IDLE and RESP.
REQ-022 A requester holding reqn high in the cycle after its rdyn SHALL be treated as a new request; back-to-back throughput is one transaction per 3 cycles plus memory wait.
REQ-023 rdy0 and rdy1 SHALL never be high in the same cycle.

Reset
REQ-024 reset low SHALL immediately (asynchronously) force: state IDLE, valid=0, rdy0=rdy1=0, err=0, addr=dout=0, rw=0, dtr0=dtr1=0, counter=0, lst=1.
REQ-025 Reset asserted mid-BUSY SHALL abort the transaction with no rdy pulse.
REQ-026 After reset deasserts, the first rising edge SHALL sample requests normally.

Structure
REQ-027 State encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the timeout counter width SHALL live in shared package hs32_mem_pkg.
REQ-028 Tie-break logic SHALL be a combinational sub-module hs32_rr_pick (inputs req0, req1, lst; outputs gnt, gnt_ch).
REQ-029 All outputs except dtr0/dtr1 mirrors SHALL be driven from registers.

Verification
REQ-030 req0=1, addr0=0x100, rw0=0, ready high 2 cycles after valid, din=0xDEADBEEF -> valid on cycle 1, addr=0x100, rdy0 pulse 1 cycle, dtr0=0xDEADBEEF, rdy1=0.
REQ-031 req0 and req1 both high from reset, ready=1 immediately each time -> grants 0,1,0,1 alternating, each rdy a single-cycle pulse.
REQ-032 req1 write addr1=0x20, dtw1=0x55; dtw1 changed to 0x66 and req1 dropped during BUSY -> dout stays 0x55 until completion, rdy1 pulses.
REQ-033 TIMEOUT=4, ready never asserted -> valid high 4 cycles, then rdy0=1, err=1, dtr0=0, valid=0.
REQ-034 reset pulsed low mid-BUSY -> valid=0 and all outputs at reset values immediately, no rdy pulse, next tie goes to channel 0.
REQ-035 Formal/assertion: rdy0&&rdy1 never; valid implies addr stable until ready; err implies exactly one rdy.
